// File: rtl/aes_pkg.sv
// Shared AES constants, helper functions and type definitions for the iterative core.
package aes_pkg;

  typedef enum logic [1:0] {
    KL128 = 2'd0,
    KL192 = 2'd1,
    KL256 = 2'd2,
    KLRSV = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    ROUND,
    DONE
  } fsm_e;

  localparam logic [0:255][7:0] SBOX_T = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_T[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL128:   return 4'd10;
      KL192:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL128:   return 4'd4;
      KL192:   return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      sb[k] = sbox(state_i[127-8*k -: 8]);
    end
    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int unsigned k = 0; k < 16; k++) begin
      state_o[127-8*k -: 8] = (final_i ? sr[k] : mc[k]) ^ rk_i[127-8*k -: 8];
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryptor: one round per cycle with an internally stored
// key schedule that is expanded one word per cycle and reused until a new key is loaded.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int KW     = 32 * MAX_NK
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [KW-1:0] key,
  input  logic [1:0]    key_len,
  input  logic          key_new,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          out_err
);

  localparam int MAX_NR = MAX_NK + 6;
  localparam int NW     = 4 * (MAX_NR + 1);
  localparam int IW     = $clog2(NW);

  fsm_e           state_q, state_d;
  logic [31:0]    sched_q [NW];
  logic           sched_valid_q;
  key_len_e       klen_q, sklen_q, in_klen;
  logic [IW-1:0]  widx_q, rbase;
  logic [2:0]     kpos_q;
  logic [3:0]     rci_q, rnd_q, nk;
  logic [127:0]   data_q, out_data_q, rk, rk0, round_out;
  logic           out_err_q, in_ready_q;
  logic           accept, in_err, kexp_last, round_final;
  logic [31:0]    w_prev, w_back, sub_in, sub_out, g, w_new;

  assign in_klen     = key_len_e'(key_len);
  assign accept      = in_valid && in_ready_q;
  assign in_err      = (in_klen == KLRSV) || (int'(nk_of(in_klen)) > MAX_NK) ||
                       (!key_new && !sched_valid_q);
  assign round_final = (rnd_q == nr_of(sklen_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_err ? DONE : (key_new ? KEXP : ROUND);
      KEXP:    if (kexp_last) state_d = ROUND;
      ROUND:   if (round_final) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q == DONE);
    out_data  = out_data_q;
    out_err   = out_err_q;
  end

  // Key expansion word path: one shared SubWord for both the RotWord and Nk=8 mid-word cases.
  always_comb begin
    nk        = nk_of(klen_q);
    w_prev    = sched_q[widx_q - IW'(1)];
    w_back    = sched_q[widx_q - IW'(nk)];
    sub_in    = (kpos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (kpos_q == 3'd0) begin
      g = sub_out ^ {rcon(rci_q), 24'h0};
    end else if (nk == 4'd8 && kpos_q == 3'd4) begin
      g = sub_out;
    end else begin
      g = w_prev;
    end
    w_new     = w_back ^ g;
    kexp_last = (widx_q == IW'(4 * nr_of(klen_q) + 3));
  end

  always_comb begin
    rbase = IW'({rnd_q, 2'b00});
    rk    = {sched_q[rbase], sched_q[rbase + IW'(1)], sched_q[rbase + IW'(2)], sched_q[rbase + IW'(3)]};
    rk0   = key_new ? key[KW-1 -: 128] : {sched_q[0], sched_q[1], sched_q[2], sched_q[3]};
  end

  aes_round u_round (
    .state_i (data_q),
    .rk_i    (rk),
    .final_i (round_final),
    .state_o (round_out)
  );

  // Round 0 (AddRoundKey with rk[0]) is folded into the accept edge; ROUND then runs r = 1..Nr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sched_valid_q <= 1'b0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
      data_q        <= '0;
      klen_q        <= KL128;
      sklen_q       <= KL128;
      widx_q        <= '0;
      kpos_q        <= '0;
      rci_q         <= '0;
      rnd_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_err) begin
              out_err_q  <= 1'b1;
              out_data_q <= '0;
            end else begin
              data_q <= in_data ^ rk0;
              rnd_q  <= 4'd1;
              if (key_new) begin
                sched_valid_q <= 1'b0;
                klen_q        <= in_klen;
                widx_q        <= IW'(nk_of(in_klen));
                kpos_q        <= '0;
                rci_q         <= 4'd1;
                for (int unsigned k = 0; k < MAX_NK; k++) begin
                  sched_q[IW'(k)] <= key[KW-1-32*k -: 32];
                end
              end
            end
          end
        end
        KEXP: begin
          sched_q[widx_q] <= w_new;
          widx_q          <= widx_q + IW'(1);
          kpos_q          <= (kpos_q == 3'(nk - 4'd1)) ? 3'd0 : kpos_q + 3'd1;
          if (kpos_q == 3'd0) rci_q <= rci_q + 4'd1;
          if (kexp_last) begin
            sklen_q       <= klen_q;
            sched_valid_q <= 1'b1;
          end
        end
        ROUND: begin
          data_q <= round_out;
          rnd_q  <= rnd_q + 4'd1;
          if (round_final) begin
            out_data_q <= round_out;
            out_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
